spi_reg_master: RTL
===================

Name: spi_reg_master

Overview:
- SPI master that drives the register-file SPI slave interface from the host side of the link.
- Also used as the bench model/driver in system simulation.
- Accepts one read or write request per frame on a simple req/done handshake and serialises an 8-bit command followed by a DATA_W-bit data word, MSB first.
- SPI mode 0: SCLK idles low, CS is active-low, MOSI changes on the falling edge, and the slave samples on the rising edge.

Parameters:
- DATA_W, 32: register data width; must match the slave's data width.
- ADDR_W, 7: address width; command byte = {rw, addr[6:0]}, so ADDR_W + 1 = 8 is fixed.
- CLK_DIV, 4: sys_clk cycles per SCLK half-period. Minimum legal value is 4 (slave uses 2-flop synchronisers plus edge detect).
- CS_GAP, 8: minimum sys_clk cycles CS stays high between frames.

Ports:
- sys_clk_i  in  1  system clock
- sys_rst_i  in  1  asynchronous active-low reset
- req_i  in  1  start request; sampled only in IDLE
- rw_i  in  1  1 = read, 0 = write; captured with req_i
- addr_i  in  ADDR_W  register address; captured with req_i
- wdata_i  in  DATA_W  write data; captured with req_i (ignored for reads)
- busy_o  out  1  high from request acceptance until done_o
- done_o  out  1  one-cycle pulse at end of frame
- rdata_o  out  DATA_W  read result; valid from done_o until the next done_o of a read
- spi_clk_o  out  1  SCLK
- spi_mosi_o  out  1  master data out
- spi_cs_o  out  1  chip select, active-low
- spi_miso_i  in  1  slave data in; 2-flop synchronised internally

Behaviour:
- Reset (sys_rst_i = 0, asynchronous):
  - FSM goes to IDLE.
  - spi_cs_o = 1, spi_clk_o = 0, spi_mosi_o = 0.
  - busy_o = 0, done_o = 0, rdata_o = 0.
  - Gap counter preloaded so that a request is accepted immediately after reset release.
  - Reset mid-frame aborts the frame: CS rises in the same instant, and no done_o is issued.
- Frame layout:
  - cmd[7] = rw_i, cmd[6:0] = addr_i; then DATA_W data bits.
  - Total N = 8 + DATA_W SCLK pulses.
  - For writes, MOSI carries wdata MSB first. For reads, MOSI is driven 0 during the data phase.
- FSM states: IDLE -> SETUP -> LOW -> HIGH -> (LOW | HOLD) -> GAP -> IDLE.
- IDLE:
  - If req_i = 1 and the gap counter has expired, latch the shift register {cmd, wdata}, set busy_o, drive CS low, and go to SETUP.
  - req_i while busy is ignored and not queued.
- SETUP:
  - CLK_DIV cycles with CS low and SCLK low.
  - MOSI = bit N-1 from the first SETUP cycle.
  - Then go to LOW.
- LOW:
  - CLK_DIV cycles, SCLK = 0.
  - On entry from HIGH, MOSI advances to the next bit (shift left).
  - Then go to HIGH.
- HIGH:
  - CLK_DIV cycles, SCLK = 1.
  - During the data phase, the synchronised MISO is sampled into the rx shift register on the last cycle of HIGH (MSB first).
  - Bit counter increments at the end of HIGH.
  - After the N-th HIGH, go to HOLD; otherwise go to LOW.
- HOLD:
  - CLK_DIV cycles, SCLK = 0, CS still low.
  - Then CS goes high. The slave commits writes on the CS rising edge.
  - In the same cycle: done_o pulses, busy_o clears, and for reads rdata_o <= rx shift register.
  - Go to GAP.
- GAP:
  - Hold CS high for CS_GAP cycles, then go to IDLE.
  - busy_o = 0 during GAP; req_i is held off until GAP ends, and the requester keeps req_i high.
- Frame length:
  - From acceptance to done_o = CLK_DIV × (2 + 2N) cycles (SETUP + N × (LOW + HIGH) + HOLD).
  - DATA_W = 32, CLK_DIV = 4: 328 cycles.
- Outputs are registered; SCLK, MOSI and CS have no combinational path from inputs.
- Counters:
  - Half-period counter width is ceil(log2(CLK_DIV)) + 1.
  - Bit counter is 8 bits wide and wraps only via reload in IDLE.

Test Plan:
- Write: req, rw = 0, addr = 0x05, wdata = 0xDEADBEEF -> CS low, 40 SCLK rising edges, MOSI bits on rising edges = 0x05 then 0xDEADBEEF MSB first; done_o after 328 cycles; slave register 5 = 0xDEADBEEF.
- Read: preload slave register 0x12 = 0xA5A5_0F0F, req rw = 1, addr = 0x12 -> command byte 0x92 on MOSI, MOSI = 0 in data phase, rdata_o = 0xA5A50F0F at done_o.
- Back-to-back: req_i held high across two writes -> CS high for ≥ CS_GAP cycles between frames, second done_o exactly 328 + CS_GAP + 1 cycles after the first.
- Busy: pulse req_i with different addr mid-frame -> ignored; current frame unaffected; single done_o.
- Reset at bit 20 of a write -> CS = 1, SCLK = 0, busy_o = 0 immediately; slave register unchanged; next request completes normally.
- CLK_DIV = 8 loopback (MISO tied to MOSI, read of addr 0x7F) -> SCLK half-period = 8 cycles; rdata_o = 0x00000000, since MOSI is 0 in the data phase.

Source files
------------

// File: rtl/spi_reg_master.sv
// SPI mode-0 master for the register-file slave: one {rw,addr} command byte
// followed by a DATA_W data word per CS-low frame, MSB first.
module spi_reg_master #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 7,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic              req_i,
  input  logic              rw_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              spi_clk_o,
  output logic              spi_mosi_o,
  output logic              spi_cs_o,
  input  logic              spi_miso_i
);

  localparam int N  = 8 + DATA_W;
  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam int GW = $clog2(CS_GAP + 1);

  localparam logic [CW-1:0] HP_LAST  = CW'(CLK_DIV - 1);
  localparam logic [7:0]    BIT_LAST = 8'(N - 1);
  localparam logic [7:0]    BIT_DATA = 8'd8;
  localparam logic [GW-1:0] GAP_LOAD = GW'(CS_GAP - 1);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_t;

  state_t            state;
  logic [CW-1:0]     hp_cnt;
  logic [7:0]        bit_cnt;
  logic [GW-1:0]     gap_cnt;
  logic [N-1:0]      tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic              rd;
  logic              miso_s1, miso_s2;
  logic              hp_last;

  assign hp_last = (hp_cnt == HP_LAST);

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      state      <= IDLE;
      hp_cnt     <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      rd         <= 1'b0;
      miso_s1    <= 1'b0;
      miso_s2    <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      rdata_o    <= '0;
      spi_clk_o  <= 1'b0;
      spi_mosi_o <= 1'b0;
      spi_cs_o   <= 1'b1;
    end else begin
      miso_s1 <= spi_miso_i;
      miso_s2 <= miso_s1;
      done_o  <= 1'b0;
      if (state != IDLE && state != GAP)
        hp_cnt <= hp_last ? '0 : hp_cnt + 1'b1;

      case (state)
        IDLE: begin
          hp_cnt  <= '0;
          bit_cnt <= '0;
          if (req_i && gap_cnt == '0) begin
            // read frames shift zeros out during the data phase
            tx_sh      <= {rw_i, addr_i, (rw_i ? {DATA_W{1'b0}} : wdata_i)};
            spi_mosi_o <= rw_i;
            rd         <= rw_i;
            busy_o     <= 1'b1;
            spi_cs_o   <= 1'b0;
            state      <= SETUP;
          end
        end
        SETUP: if (hp_last) state <= LOW;
        LOW: begin
          if (hp_last) begin
            spi_clk_o <= 1'b1;
            state     <= HIGH;
          end
        end
        HIGH: begin
          if (hp_last) begin
            spi_clk_o <= 1'b0;
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt >= BIT_DATA)
              rx_sh <= {rx_sh[DATA_W-2:0], miso_s2};
            if (bit_cnt == BIT_LAST) begin
              state <= HOLD;
            end else begin
              tx_sh      <= {tx_sh[N-2:0], 1'b0};
              spi_mosi_o <= tx_sh[N-2];
              state      <= LOW;
            end
          end
        end
        HOLD: begin
          if (hp_last) begin
            spi_cs_o   <= 1'b1;
            spi_mosi_o <= 1'b0;
            done_o     <= 1'b1;
            busy_o     <= 1'b0;
            if (rd) rdata_o <= rx_sh;
            gap_cnt    <= GAP_LOAD;
            state      <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= IDLE;
          else gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
